// File: rtl/conv_acc.sv
// conv_acc: K x K signed dot-product engine that accumulates window slices
// across input channels on top of a bias, then shifts, optionally applies
// ReLU and saturates the channel sum to O_WIDTH.
// The pipeline has three register stages:
//   P1 (accept)     -> P2 (accumulate) -> output register.
// A single enable holds every stage while a finished result waits downstream.
module conv_acc #(
  parameter int K         = 3,
  parameter int I_WIDTH   = 8,
  parameter int ACC_WIDTH = 24,
  parameter int O_WIDTH   = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_valid,
  output logic                       i_ready,
  input  logic                       i_last,
  input  logic [K*K*I_WIDTH-1:0]     i_tensor,
  input  logic [K*K*I_WIDTH-1:0]     w_tensor,
  input  logic [ACC_WIDTH-1:0]       bias,
  input  logic [4:0]                 shift,
  input  logic                       relu_en,
  output logic                       o_valid,
  input  logic                       o_ready,
  output logic [O_WIDTH-1:0]         o_tensor,
  output logic                       o_ovf
);

  localparam int TAPS = K * K;
  localparam int PW   = 2 * I_WIDTH;

  // Saturation bounds of the signed output, expressed at accumulator width.
  localparam logic signed [ACC_WIDTH-1:0] SAT_MAX =
    {{(ACC_WIDTH-O_WIDTH+1){1'b0}}, {(O_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] SAT_MIN =
    {{(ACC_WIDTH-O_WIDTH+1){1'b1}}, {(O_WIDTH-1){1'b0}}};

  // P1 stage registers
  logic                        p1_valid_q;
  logic                        p1_first_q;
  logic                        p1_last_q;
  logic signed [ACC_WIDTH-1:0] p1_psum_q;
  logic signed [ACC_WIDTH-1:0] p1_bias_q;
  logic [4:0]                  p1_shift_q;
  logic                        p1_relu_q;
  logic                        in_window_q;

  // P2 stage registers
  logic signed [ACC_WIDTH-1:0] acc_q;
  logic                        p2_fin_q;
  logic [4:0]                  p2_shift_q;
  logic                        p2_relu_q;

  // Output registers
  logic                        o_valid_q;
  logic [O_WIDTH-1:0]          o_tensor_q;
  logic                        o_ovf_q;

  // Combinational next values
  logic signed [ACC_WIDTH-1:0] psum_d;
  logic signed [ACC_WIDTH-1:0] sum_d;
  logic signed [ACC_WIDTH-1:0] shifted_d;
  logic [O_WIDTH-1:0]          fin_tensor_d;
  logic                        fin_ovf_d;

  logic en;
  logic accept;

  // The whole pipeline advances unless a held result is blocked downstream.
  assign en      = !o_valid_q || o_ready;
  assign accept  = i_valid && en;
  assign i_ready = en;

  // Full-precision signed dot product of the incoming window slice.
  always_comb begin
    logic signed [PW-1:0] a_ext;
    logic signed [PW-1:0] w_ext;
    logic signed [PW-1:0] prod;
    // NOTE: every variable gets a value before any branch or loop so no latch is inferred.
    psum_d = '0;
    a_ext  = '0;
    w_ext  = '0;
    prod   = '0;
    for (int n = 0; n < TAPS; n++) begin
      a_ext  = PW'($signed(i_tensor[n*I_WIDTH +: I_WIDTH]));
      w_ext  = PW'($signed(w_tensor[n*I_WIDTH +: I_WIDTH]));
      prod   = a_ext * w_ext;
      psum_d = psum_d + ACC_WIDTH'(prod);
    end
  end

  // P1: register the slice sum and its per-pixel control on acceptance.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p1_valid_q  <= 1'b0;
      p1_first_q  <= 1'b0;
      p1_last_q   <= 1'b0;
      p1_psum_q   <= '0;
      p1_bias_q   <= '0;
      p1_shift_q  <= '0;
      p1_relu_q   <= 1'b0;
      in_window_q <= 1'b0;
    end else if (en) begin
      // NOTE: state registers use non-blocking assignment so every stage samples pre-edge values.
      p1_valid_q <= accept;
      if (accept) begin
        p1_first_q  <= !in_window_q;
        p1_last_q   <= i_last;
        p1_psum_q   <= psum_d;
        p1_bias_q   <= bias;
        p1_shift_q  <= shift;
        p1_relu_q   <= relu_en;
        in_window_q <= !i_last;
      end
    end
  end

  // First slice of a pixel starts from the bias; later slices add to the running sum.
  assign sum_d = (p1_first_q ? p1_bias_q : acc_q) + p1_psum_q;

  // P2: accumulate across channels (wrapping) and flag completed pixels.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q      <= '0;
      p2_fin_q   <= 1'b0;
      p2_shift_q <= '0;
      p2_relu_q  <= 1'b0;
    end else if (en) begin
      p2_fin_q <= p1_valid_q && p1_last_q;
      if (p1_valid_q) begin
        acc_q      <= sum_d;
        p2_shift_q <= p1_shift_q;
        p2_relu_q  <= p1_relu_q;
      end
    end
  end

  // Finaliser: floor shift, optional ReLU, then saturate to the output width.
  always_comb begin
    shifted_d    = acc_q >>> p2_shift_q;
    fin_tensor_d = shifted_d[O_WIDTH-1:0];
    fin_ovf_d    = 1'b0;
    if (p2_relu_q && shifted_d < 0) begin
      fin_tensor_d = '0;
    end else if (shifted_d > SAT_MAX) begin
      fin_tensor_d = SAT_MAX[O_WIDTH-1:0];
      fin_ovf_d    = 1'b1;
    end else if (shifted_d < SAT_MIN) begin
      fin_tensor_d = SAT_MIN[O_WIDTH-1:0];
      fin_ovf_d    = 1'b1;
    end
  end

  // Output register: load a finished pixel, otherwise drop valid once consumed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_valid_q  <= 1'b0;
      o_tensor_q <= '0;
      o_ovf_q    <= 1'b0;
    end else if (en) begin
      o_valid_q <= p2_fin_q;
      if (p2_fin_q) begin
        o_tensor_q <= fin_tensor_d;
        o_ovf_q    <= fin_ovf_d;
      end
    end
  end

  assign o_valid  = o_valid_q;
  assign o_tensor = o_tensor_q;
  assign o_ovf    = o_ovf_q;

endmodule

// File: doc/conv_acc.md
# conv_acc

Parametrised K×K convolution engine with multi-channel accumulation. It accepts one K×K window slice per beat, computes its signed dot product with the matching weights, and accumulates slices across input channels on top of a bias. On the last channel it applies an arithmetic right shift, optional ReLU and saturation to O_WIDTH. It sits between the line-buffer/window generator and the output feature-map writer, and uses valid/ready handshakes on both sides.

## Interface
- K, 3, kernel edge; K*K taps per beat
- I_WIDTH, 8, signed width of each activation and weight tap
- ACC_WIDTH, 24, signed accumulator and bias width; must be ≥ 2*I_WIDTH + clog2(K*K)
- O_WIDTH, 8, signed output width
- clk  in  1  single clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- i_valid  in  1  beat valid
- i_ready  out  1  beat accepted on an edge where i_valid && i_ready
- i_last  in  1  beat is the final channel of the current output pixel
- i_tensor  in  K*K*I_WIDTH  taps; tap n at bits [n*I_WIDTH +: I_WIDTH], row-major
- w_tensor  in  K*K*I_WIDTH  weights, same packing
- bias  in  ACC_WIDTH  signed bias; sampled on the first beat of a pixel
- shift  in  5  right-shift amount; sampled on the last beat
- relu_en  in  1  ReLU enable; sampled on the last beat
- o_valid  out  1  result valid
- o_ready  in  1  downstream accepts the result
- o_tensor  out  O_WIDTH  signed result
- o_ovf  out  1  result was saturated; qualified by o_valid

## Operation
- Global advance: en = !o_valid || o_ready. i_ready = en, driven combinationally.
- Every pipeline register updates only when en=1. When en=0 the whole pipeline holds.
- Stage P1 (accept): psum <= Σ signed(i_tap[n]) × signed(w_tap[n]) over n = 0..K*K−1, computed at full precision and sign-extended to ACC_WIDTH.
  - Along with psum, the stage registers p1_valid, p1_first, p1_last, bias, shift and relu_en.
- first flag: an internal in_window bit clears at reset and after each accepted last beat, and sets on any other accepted beat. p1_first = !in_window at acceptance.
  - A window may be a single beat (i_last on the first beat).
- Stage P2 (accumulate), when p1_valid:
  - acc <= (p1_first ? bias : acc) + psum.
  - acc wraps modulo 2^ACC_WIDTH; there is no internal saturation.
  - If p1_last, the finaliser input is the new sum value.
- Finaliser: result is computed combinationally and registered into the output.
  - s = sum >>> shift (arithmetic, floor). A shift ≥ ACC_WIDTH yields 0 or −1.
  - If relu_en and s < 0: o_tensor = 0, o_ovf = 0.
  - Else if s > 2^(O_WIDTH−1)−1: o_tensor = max, o_ovf = 1.
  - Else if s < −2^(O_WIDTH−1): o_tensor = min, o_ovf = 1.
  - Else o_tensor = s[O_WIDTH−1:0], o_ovf = 0.
- o_valid sets when a p1_last beat is finalised. It clears when o_valid && o_ready and no new result is loaded on the same edge.
- o_tensor and o_ovf hold stable while o_valid && !o_ready.
- Bubbles: an edge with en=1 and no accepted beat gives p1_valid=0, and acc holds.
- Reset: all registers go to 0, including o_valid, o_tensor, o_ovf, acc, psum, in_window and p1_valid. i_ready reads 1 while reset is held.
  - A reset mid-window discards the partial sum. The next accepted beat is treated as first.

## Timing
- Last beat accepted at edge T: P1 at T, P2/finalise at T+1, o_valid high after edge T+2 when there is no stall.
- Latency is 2 cycles from the acceptance edge to o_valid.
- Throughput is one beat per cycle. Back-to-back single-beat pixels produce one result per cycle with o_ready=1.
- Simultaneous o_valid && o_ready and a new result arriving: the new result loads and o_valid stays 1.
- o_ready=0 with o_valid=1 drives i_ready=0 in the same cycle. No beat is lost or duplicated, and results leave in order.
- Inputs are sampled only on accepting edges. Values on non-accepting edges are don't-care.

## Test plan
- Single-beat pixel, K=3, all taps 1, all weights 2, bias 0, shift 0, relu_en 0 -> o_tensor=18, o_ovf=0, o_valid exactly 2 cycles after acceptance.
- Four-beat pixel, each beat psum 10 (taps 1, weights {10,0,…}), bias 5, shift 1 -> (45>>>1)=22. A new bias on beats 2–4 is ignored.
- Taps −1, weights 100, bias 0, shift 0: relu_en 0 -> o_tensor=−128, o_ovf=1; relu_en 1 -> o_tensor=0, o_ovf=0. Taps 100, weights 100 -> 127, o_ovf=1.
- Streaming 8 single-beat pixels with values 0..7, o_ready held low for 5 cycles mid-stream -> i_ready low during the stall, outputs 0..7 in order, o_tensor stable while stalled.
- Shift cases: sum −3 with shift 1 -> −2 (floor); shift 31 on a negative sum -> −1; shift 31 on a positive sum -> 0.
- rst pulsed after 2 beats of a 4-beat pixel -> o_valid=0, o_tensor=0, i_ready=1. The next pixel (1 beat, psum 7, bias 1) -> 8, with no residue from the discarded window.
